calc_sequencer: RTL and testbench

Control FSM for the keypad adding calculator. It sits between the keypad decoder (translated key code plus one-cycle key pulse) and a pipelined, handshaked adder. It assembles decimal operands from digit keys and sequences ADD / EQUAL / CLEAR into adder transactions. It also selects the value and error flag sent to the binary-to-BCD / display path.

---
 rtl/calc_pkg.sv | 19 +
 rtl/calc_digit_acc.sv | 45 ++++
 rtl/calc_sequencer.sv | 164 ++++++++++++++++
 tb/tb_calc_sequencer.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// Shared key codes, FSM state type and default limits for the keypad adding calculator.
package calc_pkg;

  localparam logic [3:0] KEY_LAST_DIGIT = 4'd9;
  localparam logic [3:0] KEY_ADD        = 4'd10;
  localparam logic [3:0] KEY_EQUAL      = 4'd11;
  localparam logic [3:0] KEY_CLEAR      = 4'd12;

  localparam int MAX_RESULT_DEF = 9999;

  typedef enum logic [2:0] {
    ENTER_A,
    ENTER_B,
    WAIT_ADD,
    SHOW,
    ERROR
  } calc_state_t;

endpackage

// File: rtl/calc_digit_acc.sv
// Decimal operand accumulator: acc*10+d per digit key, saturating digit count,
// leading zeros not counted. clear together with load_digit restarts from the new digit.
module calc_digit_acc #(
  parameter int MAX_DIGITS = 3,
  parameter int RES_W      = 14
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             load_digit,
  input  logic [3:0]       digit,
  output logic [RES_W-1:0] acc
);

  localparam int CNT_W = $clog2(MAX_DIGITS + 1);

  logic [RES_W-1:0] acc_reg;
  logic [CNT_W-1:0] count_reg;
  logic [RES_W-1:0] base_acc;
  logic [CNT_W-1:0] base_cnt;

  assign base_acc = clear ? '0 : acc_reg;
  assign base_cnt = clear ? '0 : count_reg;
  assign acc      = acc_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_reg   <= '0;
      count_reg <= '0;
    end else if (load_digit && (base_cnt < CNT_W'(MAX_DIGITS))) begin
      // a zero typed into an empty operand is a leading zero and does not use a slot
      if (base_acc == '0 && digit == 4'd0) begin
        acc_reg   <= '0;
        count_reg <= '0;
      end else begin
        acc_reg   <= (base_acc << 3) + (base_acc << 1) + RES_W'(digit);
        count_reg <= base_cnt + 1'b1;
      end
    end else if (clear) begin
      acc_reg   <= '0;
      count_reg <= '0;
    end
  end

endmodule

// File: rtl/calc_sequencer.sv
// Keypad calculator control FSM: builds operands, runs adder transactions, drives display.
// Optional adder watchdog compiled in with CALC_SEQ_TIMEOUT_EN.
module calc_sequencer
  import calc_pkg::*;
#(
  parameter int MAX_DIGITS     = 3,
  parameter int RES_W          = 14,
  parameter int MAX_RESULT     = MAX_RESULT_DEF,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       key_code,
  input  logic             key_pulse,
  output logic             add_start,
  output logic [RES_W-1:0] add_a,
  output logic [RES_W-1:0] add_b,
  input  logic             add_done,
  input  logic [RES_W:0]   add_sum,
  output logic [RES_W-1:0] disp_value,
  output logic             disp_err,
  output logic             busy
);

  calc_state_t      state_reg;
  logic [RES_W-1:0] acc_a_reg, result_reg, add_a_reg, add_b_reg;
  logic             chain_reg, clear_pending_reg, add_start_reg, busy_reg, disp_err_reg;
  logic [RES_W-1:0] acc;

  logic key_valid, is_digit, is_add, is_equal, is_clear;
  logic in_wait, wait_exit, go_clear, sum_over, timeout;
  logic acc_clear, acc_load;

  assign key_valid = key_pulse && (key_code <= KEY_CLEAR);
  assign is_digit  = key_valid && (key_code <= KEY_LAST_DIGIT);
  assign is_add    = key_valid && (key_code == KEY_ADD);
  assign is_equal  = key_valid && (key_code == KEY_EQUAL);
  assign is_clear  = key_valid && (key_code == KEY_CLEAR);

  assign in_wait   = (state_reg == WAIT_ADD);
  assign wait_exit = in_wait && (add_done || timeout);
  assign sum_over  = add_sum > (RES_W + 1)'(MAX_RESULT);
  // a CLEAR during a transaction only takes effect once the adder answers or times out
  assign go_clear  = (!in_wait && is_clear) || (wait_exit && (clear_pending_reg || is_clear));

  assign acc_clear = go_clear || wait_exit
                   || (state_reg == ENTER_A && is_add)
                   || (state_reg == SHOW && (is_digit || is_add));
  assign acc_load  = is_digit && (state_reg == ENTER_A || state_reg == ENTER_B || state_reg == SHOW);

  calc_digit_acc #(
    .MAX_DIGITS(MAX_DIGITS),
    .RES_W     (RES_W)
  ) u_acc (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (acc_clear),
    .load_digit(acc_load),
    .digit     (key_code),
    .acc       (acc)
  );

`ifdef CALC_SEQ_TIMEOUT_EN
  localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMR_W-1:0] timer_reg;

  assign timeout = in_wait && !add_done && (timer_reg == TMR_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (!rst_n || !in_wait) begin
      timer_reg <= '0;
    end else if (!add_done) begin
      timer_reg <= timer_reg + 1'b1;
    end
  end
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = |TIMEOUT_CYCLES;
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n || go_clear) begin
      state_reg         <= ENTER_A;
      acc_a_reg         <= '0;
      result_reg        <= '0;
      add_a_reg         <= '0;
      add_b_reg         <= '0;
      chain_reg         <= 1'b0;
      clear_pending_reg <= 1'b0;
      add_start_reg     <= 1'b0;
      busy_reg          <= 1'b0;
      disp_err_reg      <= 1'b0;
    end else begin
      add_start_reg <= 1'b0;
      case (state_reg)
        ENTER_A: begin
          if (is_add) begin
            acc_a_reg <= acc;
            state_reg <= ENTER_B;
          end else if (is_equal) begin
            result_reg <= acc;
            state_reg  <= SHOW;
          end
        end
        ENTER_B: begin
          if (is_add || is_equal) begin
            add_a_reg     <= acc_a_reg;
            add_b_reg     <= acc;
            chain_reg     <= is_add;
            add_start_reg <= 1'b1;
            busy_reg      <= 1'b1;
            state_reg     <= WAIT_ADD;
          end
        end
        WAIT_ADD: begin
          if (wait_exit) begin
            busy_reg          <= 1'b0;
            clear_pending_reg <= 1'b0;
            if (timeout || sum_over) begin
              disp_err_reg <= 1'b1;
              state_reg    <= ERROR;
            end else if (chain_reg) begin
              acc_a_reg <= add_sum[RES_W-1:0];
              state_reg <= ENTER_B;
            end else begin
              result_reg <= add_sum[RES_W-1:0];
              state_reg  <= SHOW;
            end
          end else if (is_clear) begin
            clear_pending_reg <= 1'b1;
          end
        end
        SHOW: begin
          if (is_digit) begin
            state_reg <= ENTER_A;
          end else if (is_add) begin
            acc_a_reg <= result_reg;
            state_reg <= ENTER_B;
          end
        end
        ERROR: ;
        default: state_reg <= ENTER_A;
      endcase
    end
  end

  always_comb begin
    disp_value = '0;
    case (state_reg)
      ENTER_A, ENTER_B: disp_value = acc;
      WAIT_ADD:         disp_value = acc_a_reg;
      SHOW:             disp_value = result_reg;
      default:          disp_value = '0;
    endcase
  end

  assign add_start = add_start_reg;
  assign add_a     = add_a_reg;
  assign add_b     = add_b_reg;
  assign busy      = busy_reg;
  assign disp_err  = disp_err_reg;

endmodule

// File: tb/tb_calc_sequencer.sv
// Self-checking bench for calc_sequencer: calculator reference model, emulated adder, random keys.
module tb_calc_sequencer;
  import calc_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  key_code = 4'd0;
  logic        key_pulse = 1'b0;
  logic        add_done = 1'b0;
  logic [14:0] add_sum = 15'd0;
  logic        add_start, disp_err, busy;
  logic [13:0] add_a, add_b, disp_value;

  calc_sequencer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .key_code  (key_code),
    .key_pulse (key_pulse),
    .add_start (add_start),
    .add_a     (add_a),
    .add_b     (add_b),
    .add_done  (add_done),
    .add_sum   (add_sum),
    .disp_value(disp_value),
    .disp_err  (disp_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  bit started = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- calculator reference model ----------------
  localparam int MA = 0, MB = 1, MW = 2, MS = 3, ME = 4;
  localparam int LIMIT = 9999;
  localparam int TMO = 255;
  int m_mode, m_acc, m_nd, m_a, m_res, m_ea, m_eb, m_wait;
  bit m_chain, m_pend, m_start;

  task automatic m_clear();
    m_mode = MA; m_acc = 0; m_nd = 0; m_a = 0; m_res = 0;
    m_ea = 0; m_eb = 0; m_wait = 0; m_chain = 0; m_pend = 0;
  endtask

  task automatic m_digit(input int d);
    if (m_nd < 3 && !(m_acc == 0 && d == 0)) begin
      m_acc = m_acc * 10 + d;
      m_nd++;
    end
  endtask

  task automatic model_step(input bit r, input bit kp, input int kc, input bit d, input int s);
    bit key, dig, k_add, k_eq, k_clr;
    key = kp && kc <= 12;
    dig = key && kc <= 9;
    k_add = key && kc == 10;
    k_eq = key && kc == 11;
    k_clr = key && kc == 12;
    m_start = 0;
    if (!r) begin
      m_clear();
      return;
    end
    case (m_mode)
      MA, MB: begin
        if (k_clr) m_clear();
        else if (dig) m_digit(kc);
        else if (m_mode == MA && k_add) begin m_a = m_acc; m_acc = 0; m_nd = 0; m_mode = MB; end
        else if (m_mode == MA && k_eq) begin m_res = m_acc; m_mode = MS; end
        else if (m_mode == MB && (k_add || k_eq)) begin
          m_ea = m_a; m_eb = m_acc; m_chain = k_add; m_start = 1; m_wait = 0; m_mode = MW;
        end
      end
      MW: begin
        if (d) begin
          if (m_pend || k_clr) m_clear();
          else begin
            m_acc = 0; m_nd = 0; m_pend = 0;
            if (s > LIMIT) m_mode = ME;
            else if (m_chain) begin m_a = s; m_mode = MB; end
            else begin m_res = s; m_mode = MS; end
          end
        end else begin
          if (k_clr) m_pend = 1;
`ifdef CALC_SEQ_TIMEOUT_EN
          m_wait++;
          if (m_wait == TMO) begin
            if (m_pend) m_clear();
            else begin m_mode = ME; m_pend = 0; m_acc = 0; m_nd = 0; end
          end
`endif
        end
      end
      MS: begin
        if (k_clr) m_clear();
        else if (dig) begin m_acc = 0; m_nd = 0; m_digit(kc); m_mode = MA; end
        else if (k_add) begin m_a = m_res; m_acc = 0; m_nd = 0; m_mode = MB; end
      end
      default: if (k_clr) m_clear();
    endcase
  endtask

  function automatic int exp_disp();
    case (m_mode)
      MA, MB: return m_acc;
      MW:     return m_a;
      MS:     return m_res;
      default: return 0;
    endcase
  endfunction

  always @(negedge clk) begin
    if (started) begin
      chk("add_start", {31'd0, add_start}, {31'd0, m_start});
      chk("busy", {31'd0, busy}, (m_mode == MW) ? 1 : 0);
      chk("disp_err", {31'd0, disp_err}, (m_mode == ME) ? 1 : 0);
      chk("disp_value", {18'd0, disp_value}, exp_disp());
      if (m_mode == MW) begin
        chk("add_a", {18'd0, add_a}, m_ea);
        chk("add_b", {18'd0, add_b}, m_eb);
      end
    end
  end

  // ---------------- adder emulation and stimulus ----------------
  int cd = 0, lat_fix = 0, ea = 0, eb = 0, starts_seen = 0;
  bit withhold = 0, spurious_en = 0, big_sums = 0, clear_on_done = 0;

  task automatic tick(input bit kp, input logic [3:0] kc);
    add_done = 1'b0;
    key_pulse = kp;
    key_code = kc;
    if (!rst_n) cd = 0;
    if (cd > 0) begin
      cd--;
      if (cd == 0) begin
        add_done = 1'b1;
        add_sum = (big_sums && $urandom_range(0, 5) == 0) ? 15'($urandom_range(0, 32767))
                                                           : 15'(ea + eb);
      end
    end else if (spurious_en && !add_start && $urandom_range(0, 39) == 0) begin
      add_done = 1'b1;
      add_sum = 15'($urandom_range(0, 32767));
    end
    if (add_start && rst_n) begin
      ea = add_a;
      eb = add_b;
      starts_seen++;
      cd = withhold ? 100000 : ((lat_fix > 0) ? lat_fix : $urandom_range(1, 4));
      $display("[TB] txn a=%0d b=%0d", ea, eb);
    end
    if (clear_on_done && add_done) begin
      key_pulse = 1'b1;
      key_code = KEY_CLEAR;
    end
    @(posedge clk);
    model_step(rst_n, key_pulse, int'(key_code), add_done, int'(add_sum));
    @(negedge clk);
    started = 1;
  endtask

  task automatic press(input logic [3:0] k);
    tick(1'b1, k);
    tick(1'b0, 4'd0);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 60) begin
      tick(1'b0, 4'd0);
      n++;
    end
    if (busy) chk("wait_idle_bound", 32'd1, 32'd0);
  endtask

  initial begin
    int iters;
    int n;
    int r;
    logic [3:0] k;
    rst_n = 1'b0;
    tick(1'b0, 4'd0);
    tick(1'b0, 4'd0);
    chk("reset_disp", {18'd0, disp_value}, 0);
    chk("reset_busy", {31'd0, busy}, 0);
    rst_n = 1'b1;
    tick(1'b0, 4'd0);

    // 1,2,3,4 ADD 5 EQUAL with a 3-cycle adder
    lat_fix = 3;
    press(4'd1); press(4'd2); press(4'd3); press(4'd4);
    chk("fourth_digit_ignored", {18'd0, disp_value}, 123);
    press(KEY_ADD); press(4'd5); press(KEY_EQUAL);
    wait_idle();
    chk("txn_add_a", ea, 123);
    chk("txn_add_b", eb, 5);
    chk("show_128", {18'd0, disp_value}, 128);
    lat_fix = 0;

    // leading zeros, then a chained sum
    press(KEY_CLEAR);
    press(4'd0); press(4'd0); press(4'd7);
    chk("lead_zero_disp", {18'd0, disp_value}, 7);
    chk("lead_zero_count", {30'd0, dut.u_acc.count_reg}, 1);
    n = starts_seen;
    press(KEY_ADD); press(4'd8); press(KEY_ADD); wait_idle();
    press(4'd9); press(KEY_EQUAL); wait_idle();
    chk("chain_txns", starts_seen - n, 2);
    chk("chain_24", {18'd0, disp_value}, 24);

    // repeated 999 additions until overflow
    press(KEY_CLEAR);
    press(4'd9); press(4'd9); press(4'd9); press(KEY_ADD);
    press(4'd9); press(4'd9); press(4'd9); press(KEY_EQUAL); wait_idle();
    chk("sum_1998", {18'd0, disp_value}, 1998);
    iters = 0;
    while (!disp_err && iters < 12) begin
      press(KEY_ADD); press(4'd9); press(4'd9); press(4'd9); press(KEY_EQUAL); wait_idle();
      iters++;
    end
    chk("overflow_iters", iters, 9);
    chk("overflow_err", {31'd0, disp_err}, 1);
    chk("overflow_disp", {18'd0, disp_value}, 0);
    press(4'd5);
    chk("error_digit_ignored", {31'd0, disp_err}, 1);
    press(KEY_CLEAR);
    chk("error_cleared", {31'd0, disp_err}, 0);
    press(4'd4);
    chk("after_clear_digit", {18'd0, disp_value}, 4);

    // CLEAR in the same cycle as add_done
    press(KEY_CLEAR);
    press(4'd2); press(KEY_ADD); press(4'd3);
    clear_on_done = 1;
    press(KEY_EQUAL); wait_idle();
    clear_on_done = 0;
    chk("clr_done_disp", {18'd0, disp_value}, 0);
    press(4'd6);
    chk("clr_done_enter_a", {18'd0, disp_value}, 6);

    // reset while waiting on the adder
    press(KEY_CLEAR);
    withhold = 1;
    press(4'd2); press(KEY_ADD); press(4'd3); press(KEY_EQUAL);
    tick(1'b0, 4'd0);
    chk("wait_busy", {31'd0, busy}, 1);
    rst_n = 1'b0;
    tick(1'b0, 4'd0);
    rst_n = 1'b1;
    withhold = 0;
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_disp", {18'd0, disp_value}, 0);
    n = starts_seen;
    repeat (6) tick(1'b0, 4'd0);
    chk("rst_no_refire", starts_seen - n, 0);

`ifdef CALC_SEQ_TIMEOUT_EN
    // watchdog: adder withheld
    withhold = 1;
    press(4'd2); press(KEY_ADD); press(4'd3);
    tick(1'b1, KEY_EQUAL);
    n = 0;
    while (busy && n < 400) begin
      n++;
      tick(1'b0, 4'd0);
    end
    chk("timeout_cycles", n, 255);
    chk("timeout_err", {31'd0, disp_err}, 1);
    cd = 1;
    tick(1'b0, 4'd0);
    tick(1'b0, 4'd0);
    chk("late_done_ignored", {31'd0, disp_err}, 1);
    withhold = 0;
    press(KEY_CLEAR);
`endif

    // randomized keys, random latency, spurious done and oversized sums
    spurious_en = 1;
    big_sums = 1;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 2) == 0) begin
        r = $urandom_range(0, 99);
        if (r < 50) k = 4'($urandom_range(0, 9));
        else if (r < 70) k = KEY_ADD;
        else if (r < 85) k = KEY_EQUAL;
        else if (r < 90) k = KEY_CLEAR;
        else k = 4'($urandom_range(13, 15));
        tick(1'b1, k);
      end else begin
        tick(1'b0, 4'd0);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
